// File: rtl/sm4_encryptor_pkg.sv
// sm4_encryptor: SM4 key-schedule constants, CK generator, S-box table and rotate helper
package sm4_encryptor;
  localparam int turn_key_num_p = 32;
  localparam int key_size_p = 32;
  localparam int group_size_p = 128;
  localparam logic [127:0] fk = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [7:0] sbox_t [256] = '{
    8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
    8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
    8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
    8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
    8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
    8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
    8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
    8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
    8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
    8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
    8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
    8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
    8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
    8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
    8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
  };
  function automatic logic [31:0] ck_f(input logic [4:0] i);
    logic [7:0] b;
    ck_f = '0;
    for (int j = 0; j < 4; j++) begin
      b = {1'b0, i, 2'b00} + 8'(j);
      b = b * 8'd7;
      ck_f[31-8*j -: 8] = b;
    end
  endfunction
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/sm4_sbox.sv
// sm4_sbox: combinational SM4 byte substitution
module sm4_sbox
  import sm4_encryptor::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_t[a];
endmodule

// File: rtl/key_expander.sv
// key_expander: iterative SM4 key schedule emitting rk0..rk31 one per cycle with index, valid and last
module key_expander
  import sm4_encryptor::*;
#(
  parameter int turn_num_p = turn_key_num_p,
  parameter int word_p = key_size_p,
  parameter int mkey_p = group_size_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [mkey_p-1:0]             key_i,
  input  logic                          v_i,
  output logic                          ready_o,
  output logic [word_p-1:0]             tkey_o,
  output logic [$clog2(turn_num_p)-1:0] which_turn_key_o,
  output logic                          v_o,
  output logic                          last_o
);
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state, state_n;
  logic [mkey_p-1:0] k;
  logic [$clog2(turn_num_p)-1:0] cnt;
  logic [31:0] x, b, rk;
  logic accept, run, done;
  assign ready_o = state == IDLE;
  assign accept = ready_o && v_i;
  assign run = state == EXPAND;
  assign done = run && cnt == ($clog2(turn_num_p))'(turn_num_p - 1);
  assign x = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_f(cnt);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (.a(x[8*g +: 8]), .y(b[8*g +: 8]));
  end
  assign rk = k[127:96] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
  always_comb state_n = accept ? EXPAND : done ? IDLE : state;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      tkey_o <= '0;
      which_turn_key_o <= '0;
      v_o <= 1'b0;
      last_o <= 1'b0;
    end else begin
      state <= state_n;
      v_o <= run;
      last_o <= done;
      if (accept) begin
        k <= key_i ^ fk;
        cnt <= '0;
      end else if (run) begin
        k <= {k[95:0], rk};
        tkey_o <= rk;
        which_turn_key_o <= cnt;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander: directed and random self-checking bench for key_expander
module tb_key_expander;
  logic clk = 0, reset_i = 1, v_i = 0;
  logic [127:0] key_i = '0;
  logic ready_o, v_o, last_o;
  logic [31:0] tkey_o;
  logic [4:0] which_turn_key_o;
  int checks = 0, errors = 0;
  logic [31:0] exp_rk [32];
  logic [31:0] obs_rk [32];
  logic [31:0] exp3 [3][32];
  localparam logic [7:0] SB [256] = '{
    8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
    8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
    8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
    8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
    8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
    8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
    8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
    8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
    8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
    8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
    8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
    8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
    8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
    8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
    8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
  };

  key_expander dut (
    .clk_i(clk), .reset_i(reset_i), .key_i(key_i), .v_i(v_i), .ready_o(ready_o),
    .tkey_o(tkey_o), .which_turn_key_o(which_turn_key_o), .v_o(v_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_t(input logic [31:0] x);
    logic [31:0] s;
    s = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
    return s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
  endfunction

  function automatic logic [31:0] m_ck(input int i);
    logic [31:0] c;
    for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return c;
  endfunction

  task automatic m_expand(input logic [127:0] mk);
    logic [31:0] w [36];
    w[0] = mk[127:96] ^ 32'hA3B1BAC6;
    w[1] = mk[95:64]  ^ 32'h56AA3350;
    w[2] = mk[63:32]  ^ 32'h677D9197;
    w[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      w[i+4] = w[i] ^ m_t(w[i+1] ^ w[i+2] ^ w[i+3] ^ m_ck(i));
      exp_rk[i] = w[i+4];
    end
  endtask

  task automatic run_key(input logic [127:0] mk);
    m_expand(mk);
    @(negedge clk);
    key_i = mk;
    v_i = 1;
    @(posedge clk);
    #1 v_i = 0;
    key_i = ~mk;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk);
      #1;
      obs_rk[j] = tkey_o;
      checks++;
      if (v_o !== 1'b1 || which_turn_key_o !== 5'(j) || tkey_o !== exp_rk[j]) begin
        errors++;
        $display("FAIL key[%0d] v=%b idx=%0d rk=%h required v=1 idx=%0d rk=%h", j, v_o, which_turn_key_o, tkey_o, j, exp_rk[j]);
      end
      checks++;
      if (last_o !== (j == 31) || ready_o !== (j == 31)) begin
        errors++;
        $display("FAIL flags[%0d] last=%b ready=%b required last=%b ready=%b", j, last_o, ready_o, j == 31, j == 31);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (v_o !== 1'b0 || last_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_after v=%b last=%b ready=%b required 0 0 1", v_o, last_o, ready_o);
    end
  endtask

  task automatic test_reset;
    reset_i = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_o, v_o, last_o, tkey_o, which_turn_key_o} !== {3'b100, 32'h0, 5'h0}) begin
      errors++;
      $display("FAIL reset ready=%b v=%b last=%b rk=%h idx=%0d required 1 0 0 0 0", ready_o, v_o, last_o, tkey_o, which_turn_key_o);
    end
    @(negedge clk) reset_i = 0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b v=%b required 1 0", ready_o, v_o);
    end
  endtask

  task automatic test_vector;
    run_key(128'h0123456789ABCDEFFEDCBA9876543210);
    checks++;
    if (obs_rk[0] !== 32'hF12186F9) begin errors++; $display("FAIL vec_rk0 got %h want F12186F9", obs_rk[0]); end
    checks++;
    if (obs_rk[1] !== 32'h41662B61) begin errors++; $display("FAIL vec_rk1 got %h want 41662B61", obs_rk[1]); end
    checks++;
    if (obs_rk[31] !== 32'h9124A012) begin errors++; $display("FAIL vec_rk31 got %h want 9124A012", obs_rk[31]); end
  endtask

  task automatic test_zero_key;
    logic [31:0] want;
    want = 32'hA3B1BAC6 ^ m_t(32'h56AA3350 ^ 32'h677D9197 ^ 32'hB27022DC ^ 32'h00070E15);
    run_key('0);
    checks++;
    if (obs_rk[0] !== want) begin errors++; $display("FAIL zero_rk0 got %h want %h", obs_rk[0], want); end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    int seen = 0;
    @(negedge clk);
    key_i = 128'h00112233445566778899AABBCCDDEEFF;
    v_i = 1;
    @(posedge clk);
    #1 v_i = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1 found = v_o && which_turn_key_o == 5'd10;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_wait round 10 not seen within 40 cycles"); end
    @(negedge clk) reset_i = 1;
    @(posedge clk);
    #1;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset v=%b ready=%b last=%b required 0 1 0", v_o, ready_o, last_o);
    end
    @(negedge clk) reset_i = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (v_o) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_abort keys_after_reset=%0d required 0", seen); end
  endtask

  task automatic test_back_to_back;
    int acc [3] = '{0, 33, 66};
    int lasts = 0;
    logic [127:0] pat;
    for (int n = 0; n < 3; n++) begin
      m_expand({4{32'h9E3779B9 * (acc[n] + 1)}} ^ {96'h0, 32'(acc[n])});
      for (int i = 0; i < 32; i++) exp3[n][i] = exp_rk[i];
    end
    for (int c = 0; c < 110; c++) begin
      bit ev = 0;
      int ei = 0, en = 0;
      @(negedge clk);
      pat = {4{32'h9E3779B9 * (c + 1)}} ^ {96'h0, 32'(c)};
      key_i = pat;
      v_i = c < 80;
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++)
        if (c >= acc[n] + 1 && c <= acc[n] + 32) begin ev = 1; en = n; ei = c - acc[n] - 1; end
      if (c < 80 && last_o) lasts++;
      checks++;
      if (v_o !== ev || (ev && (which_turn_key_o !== 5'(ei) || tkey_o !== exp3[en][ei] || last_o !== (ei == 31)))) begin
        errors++;
        $display("FAIL b2b[%0d] v=%b idx=%0d rk=%h last=%b required v=%b idx=%0d rk=%h", c, v_o, which_turn_key_o, tkey_o, last_o, ev, ei, exp3[en][ei]);
      end
    end
    checks++;
    if (lasts != 2) begin errors++; $display("FAIL b2b_count last pulses=%0d required 2", lasts); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 1000; n++) run_key({$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    test_reset;
    test_vector;
    test_zero_key;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
